// File: rtl/frv_imem_responder_pkg.sv
// Shared types and helpers for the instruction/data memory responder.
// XL is the bus MSB index used across the pipeline (32-bit bus).
package frv_imem_responder_pkg;

    localparam int unsigned XL   = 31;
    // Range arithmetic is one bit wider than the bus so base + span never wraps.
    localparam int unsigned RNGW = XL + 2;

    // One queued response: read data plus error flag.
    typedef struct packed {
        logic [XL:0] rdata;
        logic        error;
    } rsp_t;

    localparam int unsigned RSP_W = $bits(rsp_t);

    // True when base <= addr < base + span, evaluated in RNGW bits.
    function automatic logic addr_in_range(input logic [XL:0]     addr,
                                           input logic [XL:0]     base,
                                           input logic [RNGW-1:0] span);
        logic [RNGW-1:0] a;
        logic [RNGW-1:0] lo;
        logic [RNGW-1:0] hi;
        a  = {1'b0, addr};
        lo = {1'b0, base};
        hi = lo + span;
        return (a >= lo) && (a < hi);
    endfunction

endpackage

// File: rtl/frv_imem_responder_if.sv
// Memory bus: req/gnt request phase, recv/ack response phase.
interface frv_imem_responder_if;
    import frv_imem_responder_pkg::*;

    logic        mem_req;
    logic        mem_wen;
    logic [3:0]  mem_strb;
    logic [XL:0] mem_wdata;
    logic [XL:0] mem_addr;
    logic        mem_gnt;
    logic        mem_recv;
    logic        mem_ack;
    logic        mem_error;
    logic [XL:0] mem_rdata;

    modport master (
        output mem_req, mem_wen, mem_strb, mem_wdata, mem_addr, mem_ack,
        input  mem_gnt, mem_recv, mem_error, mem_rdata
    );

    modport slave (
        input  mem_req, mem_wen, mem_strb, mem_wdata, mem_addr, mem_ack,
        output mem_gnt, mem_recv, mem_error, mem_rdata
    );

endinterface

// File: rtl/frv_mem_rsp_fifo.sv
// In-order response FIFO with per-entry age tracking. The head is reported
// ready once its age reaches LATENCY. Age counts clock edges since the entry
// was accepted; the accept edge itself is the first one.
module frv_mem_rsp_fifo #(
    parameter int unsigned WIDTH   = 33,
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned LATENCY = 1
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic [WIDTH-1:0]           o_head_data,
    output logic                       o_head_ready
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned AGE_W = $clog2(LATENCY + 1);

    logic [WIDTH-1:0] r_data [DEPTH];
    logic [AGE_W-1:0] r_age  [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // Payload storage, written on push only.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_data[r_wr_ptr] <= i_push_data;
        end
    end

    // Age counters: saturate at LATENCY; a pushed entry starts at one edge old.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_age[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (r_age[i] != AGE_W'(LATENCY)) begin
                    r_age[i] <= r_age[i] + 1'b1;
                end
            end
            if (i_push) begin
                r_age[r_wr_ptr] <= AGE_W'(1);
            end
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (i_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count      = r_count;
    assign o_head_data  = r_data[r_rd_ptr];
    assign o_head_ready = (r_count != '0) && (r_age[r_rd_ptr] == AGE_W'(LATENCY));

endmodule

// File: rtl/frv_imem_responder.sv
// Memory-side responder: word-addressed on-chip RAM with byte-strobed writes,
// up to RSP_DEPTH in-flight transactions answered strictly in order after at
// least LATENCY cycles.
// Optional: define FRV_IMEM_RESPONDER_STALL_EN to add LFSR-driven random stalls
// of grant and response presentation for protocol stress testing.
module frv_imem_responder
    import frv_imem_responder_pkg::*;
#(
    parameter logic [XL:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned RSP_DEPTH   = 2,
    parameter int unsigned LATENCY     = 1
) (
    input  logic                  g_clk,
    input  logic                  g_reset,
    frv_imem_responder_if.slave   bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
    localparam logic [RNGW-1:0] SPAN = RNGW'(DEPTH_WORDS) << 2;

    logic [XL:0]      r_mem [DEPTH_WORDS];

    logic             w_gnt;
    logic             w_accept;
    logic             w_in_range;
    logic [RNGW-1:0]  w_offset;
    logic [IDX_W-1:0] w_idx;
    logic             w_unused_offset;
    rsp_t             w_rsp_push;
    rsp_t             w_head;
    logic             w_head_ready;
    logic [CNT_W-1:0] w_count;
    logic             w_stall;
    logic             w_recv;
    logic             w_pop;

    assign w_in_range      = addr_in_range(bus.mem_addr, BASE_ADDR, SPAN);
    assign w_offset        = {1'b0, bus.mem_addr} - {1'b0, BASE_ADDR};
    assign w_idx           = w_offset[IDX_W+1:2];
    assign w_unused_offset = ^{w_offset[RNGW-1:IDX_W+2], w_offset[1:0]};

    // Grant uses start-of-cycle occupancy, so a same-cycle pop frees nothing.
    assign w_gnt    = bus.mem_req && !g_reset && !w_stall && (w_count < CNT_W'(RSP_DEPTH));
    assign w_accept = bus.mem_req && w_gnt;
    assign w_pop    = w_recv && bus.mem_ack;

    // Byte-strobed RAM write on an in-range write accept.
    always_ff @(posedge g_clk) begin
        if (w_accept && bus.mem_wen && w_in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.mem_strb[i]) begin
                    r_mem[w_idx][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
                end
            end
        end
    end

    // Response captured at accept; reads see every write from earlier cycles.
    always_comb begin
        w_rsp_push.error = !w_in_range;
        w_rsp_push.rdata = '0;
        if (!bus.mem_wen && w_in_range) begin
            w_rsp_push.rdata = r_mem[w_idx];
        end
    end

    frv_mem_rsp_fifo #(
        .WIDTH   (RSP_W),
        .DEPTH   (RSP_DEPTH),
        .LATENCY (LATENCY)
    ) u_rsp_fifo (
        .i_clk        (g_clk),
        .i_reset      (g_reset),
        .i_push       (w_accept),
        .i_push_data  (w_rsp_push),
        .i_pop        (w_pop),
        .o_count      (w_count),
        .o_head_data  (w_head),
        .o_head_ready (w_head_ready)
    );

`ifdef FRV_IMEM_RESPONDER_STALL_EN
    logic [15:0] r_lfsr;
    logic        r_presented;

    // Fibonacci LFSR, taps 16,14,13,11; bit 0 selects a stall cycle.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end

    // Remember that the head has been shown so a stall never withdraws it.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            r_presented <= 1'b0;
        end else if (w_pop) begin
            r_presented <= 1'b0;
        end else if (w_recv) begin
            r_presented <= 1'b1;
        end
    end

    assign w_stall = r_lfsr[0];
    assign w_recv  = !g_reset && w_head_ready && (!w_stall || r_presented);
`else
    assign w_stall = 1'b0;
    assign w_recv  = !g_reset && w_head_ready;
`endif

    assign bus.mem_gnt   = w_gnt;
    assign bus.mem_recv  = w_recv;
    assign bus.mem_rdata = w_recv ? w_head.rdata : '0;
    assign bus.mem_error = w_recv ? w_head.error : 1'b0;

endmodule
